// File: rtl/jump_control_seq_if.sv
// Datapath-facing bundle of the jump/branch control sequencer.
//   master : the sequencer (drives strobes and status, samples start/run/ir_in/con_ff/mem_ready)
//   slave  : datapath / controller side (drives start/run/ir_in/con_ff/mem_ready)
// Signals:
//   start, run            sequence control
//   ir_in                 instruction register contents
//   con_ff                branch condition flip-flop
//   mem_ready             memory data valid for MDR capture
//   PC_out..C_out         datapath strobes
//   link_sel, link_idx    link register write override and its index
//   op_sel                ALU operation select
//   step, busy, done, illegal, fault   status
interface jump_control_seq_if #(
   parameter int DATA_W = 32,
   parameter int ALU_W  = 5
);
   logic              start;
   logic              run;
   logic [DATA_W-1:0] ir_in;
   logic              con_ff;
   logic              mem_ready;

   logic              PC_out;
   logic              MARin;
   logic              IncPC;
   logic              Zlowin;
   logic              Zlo_out;
   logic              PCin;
   logic              Read;
   logic              MDRin;
   logic              MDR_out;
   logic              IRin;
   logic              Gra;
   logic              R_out;
   logic              Rin;
   logic              CONin;
   logic              Yin;
   logic              C_out;

   logic              link_sel;
   logic [3:0]        link_idx;
   logic [ALU_W-1:0]  op_sel;
   logic [2:0]        step;
   logic              busy;
   logic              done;
   logic              illegal;
   logic              fault;

   modport master (
      input  start, run, ir_in, con_ff, mem_ready,
      output PC_out, MARin, IncPC, Zlowin, Zlo_out, PCin, Read, MDRin, MDR_out, IRin,
      output Gra, R_out, Rin, CONin, Yin, C_out,
      output link_sel, link_idx, op_sel, step, busy, done, illegal, fault
   );

   modport slave (
      output start, run, ir_in, con_ff, mem_ready,
      input  PC_out, MARin, IncPC, Zlowin, Zlo_out, PCin, Read, MDRin, MDR_out, IRin,
      input  Gra, R_out, Rin, CONin, Yin, C_out,
      input  link_sel, link_idx, op_sel, step, busy, done, illegal, fault
   );
endinterface

// File: rtl/jump_control_seq.sv
// Control-step sequencer for instruction fetch and the jump/branch class (jr, jal, br).
// Drives the datapath strobes step by step from a clocked FSM, with a memory-ready wait
// in T1 bounded by MEM_TMO cycles (sticky fault on expiry) and an optional continuous-run
// mode that restarts fetch straight after DONE.
// Ports:
//   clk   system clock, rising edge
//   clr   asynchronous active-high reset
//   bus   jump_control_seq_if.master (handshake, IR, condition, strobes, status)
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | waiting for start (start ignored while fault is set)
// S_T0       | PC -> MAR, PC+1 -> Z
// S_T1       | Z -> PC, memory read into MDR; waits for mem_ready
// S_T2       | MDR -> IR
// S_T3       | opcode-dependent step (jr/jal/br), nothing for illegal opcodes
// S_T4_JAL   | R[ra] -> PC
// S_T4_BR    | PC -> Y
// S_T5_BR    | Y + C -> Z
// S_T6_BR    | Z -> PC when con_ff is set
// S_DONE     | done pulse
// S_DONE_ILL | done pulse with illegal
module jump_control_seq #(
   parameter int              DATA_W   = 32,
   parameter int              OP_W     = 5,
   parameter logic [OP_W-1:0] OP_BR    = 5'b10010,
   parameter logic [OP_W-1:0] OP_JAL   = 5'b10011,
   parameter logic [OP_W-1:0] OP_JR    = 5'b10100,
   parameter int              ALU_W    = 5,
   parameter logic [ALU_W-1:0] ALU_ADD = 5'b00011,
   parameter int              LINK_REG = 15,
   parameter int              MEM_TMO  = 8
) (
   input logic               clk,
   input logic               clr,
   jump_control_seq_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_T0,
      S_T1,
      S_T2,
      S_T3,
      S_T4_JAL,
      S_T4_BR,
      S_T5_BR,
      S_T6_BR,
      S_DONE,
      S_DONE_ILL
   } state_t;

   // strobe vector bit masks
   localparam logic [15:0] M_PC_OUT  = 16'h0001;
   localparam logic [15:0] M_MARIN   = 16'h0002;
   localparam logic [15:0] M_INCPC   = 16'h0004;
   localparam logic [15:0] M_ZLOWIN  = 16'h0008;
   localparam logic [15:0] M_ZLO_OUT = 16'h0010;
   localparam logic [15:0] M_PCIN    = 16'h0020;
   localparam logic [15:0] M_READ    = 16'h0040;
   localparam logic [15:0] M_MDRIN   = 16'h0080;
   localparam logic [15:0] M_MDR_OUT = 16'h0100;
   localparam logic [15:0] M_IRIN    = 16'h0200;
   localparam logic [15:0] M_GRA     = 16'h0400;
   localparam logic [15:0] M_R_OUT   = 16'h0800;
   localparam logic [15:0] M_RIN     = 16'h1000;
   localparam logic [15:0] M_CONIN   = 16'h2000;
   localparam logic [15:0] M_YIN     = 16'h4000;
   localparam logic [15:0] M_C_OUT   = 16'h8000;

   localparam int               CNT_W = $clog2(MEM_TMO + 1);
   localparam logic [CNT_W-1:0] TMO_C = CNT_W'(MEM_TMO);

   state_t           state_q;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] cnt_inc;
   logic             fault_set;
   logic             fault_q;

   logic [15:0]      strb_q;
   logic [ALU_W-1:0] op_sel_q;
   logic [2:0]       step_q;
   logic             busy_q;
   logic             done_q;
   logic             illegal_q;

   logic [OP_W-1:0]  opcode;
   logic             is_jr;
   logic             is_jal;
   logic             is_br;
   logic             in_t3;
   logic             in_t6;
   logic             unused_ir;

   assign opcode    = bus.ir_in[DATA_W-1 -: OP_W];
   assign unused_ir = ^bus.ir_in[DATA_W-OP_W-1:0];
   assign is_jr     = (opcode == OP_JR);
   assign is_jal    = (opcode == OP_JAL);
   assign is_br     = (opcode == OP_BR);
   assign cnt_inc   = cnt_q + CNT_W'(1);

   function automatic logic [15:0] strobes_of(input state_t s);
      logic [15:0] m;
      m = '0;
      case (s)
         S_T0:     m = M_PC_OUT | M_MARIN | M_INCPC | M_ZLOWIN;
         S_T1:     m = M_ZLO_OUT | M_PCIN | M_READ | M_MDRIN;
         S_T2:     m = M_MDR_OUT | M_IRIN;
         S_T4_JAL: m = M_GRA | M_R_OUT | M_PCIN;
         S_T4_BR:  m = M_PC_OUT | M_YIN;
         S_T5_BR:  m = M_C_OUT | M_ZLOWIN;
         S_T6_BR:  m = M_ZLO_OUT;
         default:  m = '0;
      endcase
      return m;
   endfunction

   function automatic logic [2:0] step_of(input state_t s);
      logic [2:0] t;
      case (s)
         S_T1:              t = 3'd1;
         S_T2:              t = 3'd2;
         S_T3:              t = 3'd3;
         S_T4_JAL, S_T4_BR: t = 3'd4;
         S_T5_BR:           t = 3'd5;
         S_T6_BR:           t = 3'd6;
         default:           t = 3'd0;
      endcase
      return t;
   endfunction

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      fault_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start && !fault_q) state_nxt = S_T0;
         end
         S_T0: begin
            cnt_nxt   = '0;
            state_nxt = S_T1;
         end
         S_T1: begin
            // ready on the timeout cycle still counts as a successful read
            if (bus.mem_ready) begin
               state_nxt = S_T2;
            end else if (cnt_inc == TMO_C) begin
               fault_set = 1'b1;
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         S_T2: state_nxt = S_T3;
         S_T3: begin
            if (is_jr)       state_nxt = S_DONE;
            else if (is_jal) state_nxt = S_T4_JAL;
            else if (is_br)  state_nxt = S_T4_BR;
            else             state_nxt = S_DONE_ILL;
         end
         S_T4_JAL: state_nxt = S_DONE;
         S_T4_BR:  state_nxt = S_T5_BR;
         S_T5_BR:  state_nxt = S_T6_BR;
         S_T6_BR:  state_nxt = S_DONE;
         S_DONE, S_DONE_ILL: state_nxt = bus.run ? S_T0 : S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         fault_q   <= 1'b0;
         strb_q    <= '0;
         op_sel_q  <= '0;
         step_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         cnt_q     <= cnt_nxt;
         if (fault_set) fault_q <= 1'b1;
         strb_q    <= strobes_of(state_nxt);
         op_sel_q  <= (state_nxt == S_T5_BR) ? ALU_ADD : '0;
         step_q    <= step_of(state_nxt);
         busy_q    <= (state_nxt != S_IDLE);
         done_q    <= (state_nxt == S_DONE) || (state_nxt == S_DONE_ILL);
         illegal_q <= (state_nxt == S_DONE_ILL);
      end
   end

   // T3 depends on the IR that was only loaded at the end of T2, and the T6 PC load on
   // con_ff as it stands in T6, so those terms are qualified by the current state here.
   assign in_t3 = (state_q == S_T3);
   assign in_t6 = (state_q == S_T6_BR);

   assign bus.PC_out   = strb_q[0]  | (in_t3 & is_jal);
   assign bus.MARin    = strb_q[1];
   assign bus.IncPC    = strb_q[2];
   assign bus.Zlowin   = strb_q[3];
   assign bus.Zlo_out  = strb_q[4];
   assign bus.PCin     = strb_q[5]  | (in_t3 & is_jr) | (in_t6 & bus.con_ff);
   assign bus.Read     = strb_q[6];
   assign bus.MDRin    = strb_q[7];
   assign bus.MDR_out  = strb_q[8];
   assign bus.IRin     = strb_q[9];
   assign bus.Gra      = strb_q[10] | (in_t3 & (is_jr | is_br));
   assign bus.R_out    = strb_q[11] | (in_t3 & (is_jr | is_br));
   assign bus.Rin      = strb_q[12] | (in_t3 & is_jal);
   assign bus.CONin    = strb_q[13] | (in_t3 & is_br);
   assign bus.Yin      = strb_q[14];
   assign bus.C_out    = strb_q[15];

   assign bus.link_sel = in_t3 & is_jal;
   assign bus.link_idx = 4'(LINK_REG);
   assign bus.op_sel   = op_sel_q;
   assign bus.step     = step_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.illegal  = illegal_q;
   assign bus.fault    = fault_q;

endmodule
